serial_to_parallel: RTL and testbench

- Receive-side deserializer, sits directly downstream of the MRAM read-path parallel-to-serial stage.
- Collects an MSB-first serial bit stream, qualified by a per-bit strobe, into DATA_W-bit words.
- Presents each completed word on a valid/ready output handshake to the consumer (capture logic / host interface).
- Flags overrun (word lost while the consumer is stalled) and framing errors (end-of-transmission seen mid-word).

---
 rtl/rx_pkg.sv | 12 +
 rtl/rx_out_reg.sv | 45 ++++
 rtl/serial_to_parallel.sv | 92 +++++++++
 tb/tb_serial_to_parallel.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared receive-path definitions: default word geometry and the deserializer FSM encoding.
package rx_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_CNT_W  = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_t;

endpackage : rx_pkg

// File: rtl/rx_out_reg.sv
// Single-entry valid/ready holding register; a load that arrives while the
// entry is still held and not being accepted is dropped and flagged as overrun.
module rx_out_reg #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  input  logic              clear_err,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              overrun
);

  logic accept;
  logic drop;

  assign accept = valid && ready;
  assign drop   = load && valid && !ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (load && !drop) begin
        data  <= load_data;
        valid <= 1'b1;
      end else if (accept) begin
        valid <= 1'b0;
      end

      // A new drop outranks a simultaneous clear
      if (drop) begin
        overrun <= 1'b1;
      end else if (clear_err) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule : rx_out_reg

// File: rtl/serial_to_parallel.sv
// MSB-first deserializer: gathers strobed serial bits into DATA_W-bit words and
// hands them to a valid/ready consumer, flagging overrun and framing errors.
module serial_to_parallel
  import rx_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic              serial_in,
  input  logic              eot_in,
  input  logic              clear_err,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              overrun,
  output logic              frame_error
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  rx_state_t         state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_next;
  logic              complete;
  logic              abort;

  assign shift_next = {shift_reg[DATA_W-2:0], serial_in};
  assign complete   = sample_en && (bit_cnt == LAST_BIT);
  // A completing sample beats a same-cycle end-of-transmission
  assign abort      = (state == SHIFT) && eot_in && !complete;

  assign busy = (state == SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      frame_error <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sample_en) begin
            shift_reg <= shift_next;
            bit_cnt   <= CNT_W'(1);
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (complete || abort) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            state     <= IDLE;
          end else if (sample_en) begin
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
        end
      endcase

      if (abort) begin
        frame_error <= 1'b1;
      end else if (clear_err) begin
        frame_error <= 1'b0;
      end
    end
  end

  rx_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (complete),
    .load_data (shift_next),
    .ready     (data_ready),
    .clear_err (clear_err),
    .data      (data_out),
    .valid     (data_valid),
    .overrun   (overrun)
  );

endmodule : serial_to_parallel

// File: tb/tb_serial_to_parallel.sv
// Directed plus randomized bench for serial_to_parallel, checked every cycle
// against a word-level reference model.
module tb_serial_to_parallel;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sample_en = 1'b0;
  logic         serial_in = 1'b0;
  logic         eot_in = 1'b0;
  logic         clear_err = 1'b0;
  logic         data_ready = 1'b0;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         busy;
  logic         overrun;
  logic         frame_error;

  int checks = 0;
  int errors = 0;

  // Reference model state: bits gathered so far and their numeric value
  int          m_bits;
  int unsigned m_acc;
  int unsigned m_data;
  bit          m_valid;
  bit          m_ovr;
  bit          m_ferr;
  bit          ready_lvl;

  serial_to_parallel #(
    .DATA_W (W),
    .CNT_W  (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_en   (sample_en),
    .serial_in   (serial_in),
    .eot_in      (eot_in),
    .clear_err   (clear_err),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .busy        (busy),
    .overrun     (overrun),
    .frame_error (frame_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ":data_valid"},  32'(data_valid),  32'(m_valid));
    chk({ctx, ":data_out"},    32'(data_out),    m_data);
    chk({ctx, ":busy"},        32'(busy),        32'(m_bits > 0));
    chk({ctx, ":overrun"},     32'(overrun),     32'(m_ovr));
    chk({ctx, ":frame_error"}, 32'(frame_error), 32'(m_ferr));
  endtask

  task automatic model_reset();
    m_bits  = 0;
    m_acc   = 0;
    m_data  = 0;
    m_valid = 0;
    m_ovr   = 0;
    m_ferr  = 0;
  endtask

  // One clock: drive inputs, advance the model across the edge, then compare
  task automatic cyc(input bit s, input bit b, input bit e, input bit r, input bit c,
                     input string ctx);
    bit          done;
    bit          acc_ok;
    bit          drop;
    int unsigned nxt;
    sample_en  = s;
    serial_in  = b;
    eot_in     = e;
    data_ready = r;
    clear_err  = c;
    @(posedge clk);
    nxt    = (m_acc * 2 + 32'(b)) % (1 << W);
    done   = s && (m_bits == W - 1);
    acc_ok = m_valid && r;
    drop   = 0;
    if (done) begin
      if (!m_valid || acc_ok) begin
        m_data  = nxt;
        m_valid = 1;
      end else begin
        drop = 1;
      end
      m_bits = 0;
      m_acc  = 0;
    end else begin
      if (e && m_bits > 0) begin
        m_ferr = 1;
        m_bits = 0;
        m_acc  = 0;
      end else if (e && m_bits == 0 && c) begin
        m_ferr = 0;
        if (s) begin
          m_bits++;
          m_acc = nxt;
        end
      end else begin
        if (c) m_ferr = 0;
        if (s) begin
          m_bits++;
          m_acc = nxt;
        end
      end
      if (acc_ok) m_valid = 0;
    end
    if (done && c) m_ferr = 0;
    if (drop) m_ovr = 1;
    else if (c) m_ovr = 0;
    #1;
    check_all(ctx);
  endtask

  task automatic send_word(input logic [W-1:0] w, input int gap, input bit e_last,
                           input bit r_last, input string ctx);
    for (int i = W - 1; i >= 0; i--) begin
      cyc(1'b1, w[i], (i == 0) && e_last, (i == 0) ? r_last : ready_lvl, 1'b0, ctx);
      if (i > 0) begin
        for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 1'b0, ready_lvl, 1'b0, ctx);
      end
    end
  endtask

  task automatic async_reset(input string ctx);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk({ctx, ":rst_data_valid"},  32'(data_valid),  32'd0);
    chk({ctx, ":rst_data_out"},    32'(data_out),    32'd0);
    chk({ctx, ":rst_busy"},        32'(busy),        32'd0);
    chk({ctx, ":rst_overrun"},     32'(overrun),     32'd0);
    chk({ctx, ":rst_frame_error"}, 32'(frame_error), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] w;
    model_reset();
    ready_lvl = 1;

    // Power-on reset
    #3;
    check_all("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic word, consumer always ready
    send_word(16'hA5C3, 0, 1'b0, 1'b1, "basic");
    chk("basic_word", 32'(data_out), 32'h0000_A5C3);
    cyc(0, 0, 0, 1, 0, "basic_drain");
    cyc(0, 0, 0, 1, 0, "idle");

    // Gapped strobes
    send_word(16'h1234, 3, 1'b0, 1'b1, "gapped");
    chk("gapped_word", 32'(data_out), 32'h0000_1234);
    cyc(0, 0, 0, 1, 0, "gapped_drain");

    // Back-pressure and overrun
    ready_lvl = 0;
    send_word(16'hFFFF, 0, 1'b0, 1'b0, "bp_first");
    send_word(16'h0001, 0, 1'b0, 1'b0, "bp_second");
    chk("bp_hold_word", 32'(data_out), 32'h0000_FFFF);
    chk("bp_overrun", 32'(overrun), 32'd1);
    cyc(0, 0, 0, 1, 0, "bp_accept");
    cyc(0, 0, 0, 0, 1, "bp_clear");
    chk("bp_overrun_cleared", 32'(overrun), 32'd0);

    // Same-cycle accept and complete
    send_word(16'h1111, 0, 1'b0, 1'b0, "sc_first");
    send_word(16'hBEEF, 0, 1'b0, 1'b1, "sc_second");
    chk("sc_word", 32'(data_out), 32'h0000_BEEF);
    chk("sc_valid", 32'(data_valid), 32'd1);
    chk("sc_no_overrun", 32'(overrun), 32'd0);
    ready_lvl = 1;
    cyc(0, 0, 0, 1, 0, "sc_drain");

    // Framing: abort after 7 bits, then a clean word, then eot on the last bit
    w = 16'h3C3C;
    for (int i = 0; i < 7; i++) cyc(1, w[W-1-i], 0, 1, 0, "frame_partial");
    cyc(0, 0, 1, 1, 0, "frame_eot");
    chk("frame_error_set", 32'(frame_error), 32'd1);
    chk("frame_busy_low", 32'(busy), 32'd0);
    send_word(16'h8001, 0, 1'b0, 1'b1, "frame_next");
    chk("frame_next_word", 32'(data_out), 32'h0000_8001);
    send_word(16'h5A5A, 0, 1'b1, 1'b1, "frame_eot_last");
    chk("frame_eot_last_word", 32'(data_out), 32'h0000_5A5A);
    cyc(0, 0, 0, 1, 1, "frame_clear");

    // Async reset mid-word, then while holding a word
    w = 16'h7777;
    for (int i = 0; i < 9; i++) cyc(1, w[W-1-i], 0, 1, 0, "rst_mid");
    async_reset("rst_mid");
    ready_lvl = 0;
    send_word(16'hCAFE, 0, 1'b0, 1'b0, "rst_hold");
    async_reset("rst_hold");
    ready_lvl = 1;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, "rst_after");
    send_word(16'h0F0F, 0, 1'b0, 1'b1, "rst_recover");
    chk("rst_recover_word", 32'(data_out), 32'h0000_0F0F);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      cyc(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
          ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 29) == 0), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_serial_to_parallel
